// File: rtl/lcd_busy_poller.sv
// Purpose : HD44780 busy-flag poller. Issues RS=0/RW=1 read cycles with timed E pulses,
//           samples DB7 (busy) and DB6..0 (address counter), repolls until not-busy or MAX_POLLS.
// Latency : done in cycle T_AS+T_PW+T_H+1 after start; each extra poll adds 1+T_GAP+T_AS+T_PW+T_H.
// Backpr. : start is accepted only while ready=1; requests while busy are dropped, not queued.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 poll request (sampled in IDLE only)
//   data_in[7:0]          LCD DB7..DB0 from the pads
//   RS, RW, E             LCD control lines (RS fixed at 0)
//   bus_read              1 = pads released, LCD drives DB
//   ready                 1 while IDLE
//   done, timeout         single-cycle completion pulses (mutually exclusive)
//   addr_cnt[6:0]         DB6..DB0 from the most recent read
module lcd_busy_poller #(
  parameter int T_AS      = 2,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int T_GAP     = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic       bus_read,
  output logic       ready,
  output logic       done,
  output logic       timeout,
  output logic [6:0] addr_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EHIGH = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Timer reload values: a phase of N cycles loads N-1 and leaves when it reads 0.
  localparam logic [7:0] AS_LD   = 8'(T_AS - 1);
  localparam logic [7:0] PW_LD   = 8'(T_PW - 1);
  localparam logic [7:0] H_LD    = 8'(T_H - 1);
  localparam logic [7:0] GAP_LD  = 8'(T_GAP - 1);
  localparam logic [7:0] LAST_PL = 8'(MAX_POLLS - 1);

  state_t     state;
  logic [7:0] timer;
  logic [7:0] poll_cnt;
  logic       busy_q;

  // Only the instruction register is ever read.
  assign RS = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= 8'd0;
      poll_cnt <= 8'd0;
      busy_q   <= 1'b0;
      RW       <= 1'b0;
      E        <= 1'b0;
      bus_read <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      timeout  <= 1'b0;
      addr_cnt <= 7'd0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            timer    <= AS_LD;
            poll_cnt <= 8'd0;
            RW       <= 1'b1;
            bus_read <= 1'b1;
            ready    <= 1'b0;
          end
        end
        SETUP: begin
          if (timer == 8'd0) begin
            state <= EHIGH;
            timer <= PW_LD;
            E     <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        EHIGH: begin
          // The edge that drops E is the sample point for the read data.
          if (timer == 8'd0) begin
            state    <= HOLD;
            timer    <= H_LD;
            E        <= 1'b0;
            busy_q   <= data_in[7];
            addr_cnt <= data_in[6:0];
          end else begin
            timer <= timer - 8'd1;
          end
        end
        HOLD: begin
          // Pulses are registered here so they are visible during the CHECK cycle.
          if (timer == 8'd0) begin
            state   <= CHECK;
            done    <= ~busy_q;
            timeout <= busy_q && (poll_cnt == LAST_PL);
          end else begin
            timer <= timer - 8'd1;
          end
        end
        CHECK: begin
          if (!busy_q || (poll_cnt == LAST_PL)) begin
            state    <= IDLE;
            RW       <= 1'b0;
            bus_read <= 1'b0;
            ready    <= 1'b1;
          end else begin
            state    <= GAP;
            timer    <= GAP_LD;
            poll_cnt <= poll_cnt + 8'd1;
          end
        end
        GAP: begin
          if (timer == 8'd0) begin
            state <= SETUP;
            timer <= AS_LD;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          RW       <= 1'b0;
          E        <= 1'b0;
          bus_read <= 1'b0;
          ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_busy_poller.sv
// Directed bench for lcd_busy_poller: default instance plus a MAX_POLLS=4 instance,
// a negedge monitor that records E edges, pulses and protocol violations per run.
module tb_lcd_busy_poller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       rs, rw, e, bus_read, ready, done, timeout;
  logic [6:0] addr_cnt;
  logic       rs4, rw4, e4, bus_read4, ready4, done4, timeout4;
  logic [6:0] addr_cnt4;

  lcd_busy_poller u_dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .RS(rs), .RW(rw), .E(e), .bus_read(bus_read), .ready(ready),
    .done(done), .timeout(timeout), .addr_cnt(addr_cnt)
  );

  lcd_busy_poller #(.MAX_POLLS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .RS(rs4), .RW(rw4), .E(e4), .bus_read(bus_read4), .ready(ready4),
    .done(done4), .timeout(timeout4), .addr_cnt(addr_cnt4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-run monitor state; cycle numbers are relative to t0 (cycle 0 = start cycle).
  int t0 = 0;
  int e_cnt, e_last, done_cnt, done_cyc, to_cnt, ready_ret;
  int e_rise [8];
  int e4_cnt, done4_cnt, to4_cnt, to4_cyc;
  int viol = 0;
  logic e_prev = 1'b0, rw_prev = 1'b0, e4_prev = 1'b0, rw4_prev = 1'b0;

  task automatic clear_mon();
    e_cnt = 0; e_last = -1; done_cnt = 0; done_cyc = -1; to_cnt = 0; ready_ret = -1;
    for (int i = 0; i < 8; i++) e_rise[i] = -1;
    e4_cnt = 0; done4_cnt = 0; to4_cnt = 0; to4_cyc = -1;
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (e && !e_prev) begin
      if (e_cnt < 8) e_rise[e_cnt] = rel;
      e_cnt++;
    end
    if (e) e_last = rel;
    if (done) begin done_cnt++; done_cyc = rel; end
    if (timeout) to_cnt++;
    if (ready && ready_ret < 0 && rel > 0) ready_ret = rel;
    if (e4 && !e4_prev) e4_cnt++;
    if (done4) done4_cnt++;
    if (timeout4) begin to4_cnt++; to4_cyc = rel; end
    // Protocol rules: E implies RW, RW stable while E high, no double pulse, RS=0.
    if (e && !rw) viol++;
    if (e4 && !rw4) viol++;
    if (e && e_prev && (rw != rw_prev)) viol++;
    if (e4 && e4_prev && (rw4 != rw4_prev)) viol++;
    if ((done && timeout) || (done4 && timeout4)) viol++;
    if (rs || rs4) viol++;
    e_prev = e; rw_prev = rw; e4_prev = e4; rw4_prev = rw4;
  end

  task automatic start_poll();
    @(posedge clk); #1;
    clear_mon();
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_end(input string tag, input bit use4);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (use4) seen = (done4_cnt + to4_cnt) > 0;
      else      seen = (done_cnt + to_cnt) > 0;
    end
    if (!seen) chk({tag, "_wait_expired"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_case1(input string p);
    chk({p, "_e_first"},  e_rise[0], 3);
    chk({p, "_e_last"},   e_last, 14);
    chk({p, "_e_cnt"},    e_cnt, 1);
    chk({p, "_done_cyc"}, done_cyc, 17);
    chk({p, "_done_cnt"}, done_cnt, 1);
    chk({p, "_to_cnt"},   to_cnt, 0);
    chk({p, "_ready_ret"}, ready_ret, 18);
    chk({p, "_addr"},     int'(addr_cnt), 5);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw", int'(rw), 0);
    chk("rst_e", int'(e), 0);
    chk("rst_bus_read", int'(bus_read), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_addr", int'(addr_cnt), 0);
    reset = 1'b0;

    // 1: single not-busy poll
    data_in = 8'h05;
    start_poll();
    wait_end("t1", 1'b0);
    chk_case1("t1");

    // 2: three busy polls then not-busy
    data_in = 8'h83;
    start_poll();
    wait_rel(60);
    data_in = 8'h03;
    wait_end("t2", 1'b0);
    chk("t2_e_cnt", e_cnt, 4);
    chk("t2_period", e_rise[1] - e_rise[0], 21);
    chk("t2_e4_rise", e_rise[3], 66);
    chk("t2_done_cyc", done_cyc, 80);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_to_cnt", to_cnt, 0);
    chk("t2_addr", int'(addr_cnt), 3);

    // 3: MAX_POLLS=4 instance, always busy
    data_in = 8'hFF;
    start_poll();
    wait_end("t3", 1'b1);
    chk("t3_e_cnt", e4_cnt, 4);
    chk("t3_to_cnt", to4_cnt, 1);
    chk("t3_to_cyc", to4_cyc, 80);
    chk("t3_done_cnt", done4_cnt, 0);
    chk("t3_addr", int'(addr_cnt4), 8'h7F);
    chk("t3_ready", int'(ready4), 1);
    // the 255-poll instance is still polling; clear it
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 4: reset in the 5th EHIGH cycle, then a clean poll
    data_in = 8'h05;
    start_poll();
    wait_rel(7);
    chk("t4_e_before", int'(e), 1);
    reset = 1'b1;
    wait_rel(8);
    chk("t4_e", int'(e), 0);
    chk("t4_rw", int'(rw), 0);
    chk("t4_bus_read", int'(bus_read), 0);
    chk("t4_ready", int'(ready), 1);
    reset = 1'b0;
    wait_rel(40);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_no_to", to_cnt, 0);
    start_poll();
    wait_end("t4b", 1'b0);
    chk_case1("t4b");

    // 5: busy at the sample edge, clears one cycle later
    data_in = 8'h80;
    start_poll();
    wait_rel(15);
    data_in = 8'h00;
    wait_end("t5", 1'b0);
    chk("t5_e_cnt", e_cnt, 2);
    chk("t5_done_cyc", done_cyc, 38);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: start held high; re-accepted only when IDLE
    data_in = 8'h00;
    @(posedge clk); #1;
    clear_mon();
    t0 = cyc;
    start = 1'b1;
    wait_rel(36);
    start = 1'b0;
    wait_rel(70);
    chk("t6_e_cnt", e_cnt, 2);
    chk("t6_e2_rise", e_rise[1], 21);
    chk("t6_done_cnt", done_cnt, 2);
    chk("t6_done_cyc", done_cyc, 35);
    chk("t6_ready", int'(ready), 1);

    chk("protocol_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
